// File: rtl/cmat_operand_sequencer.sv
// rtl/cmat_operand_sequencer.sv - buffers two NxN complex matrices and replays (A[i][k], B[k][j]) operand pairs
module cmat_operand_sequencer #(
  parameter int N = 4,
  parameter int W = 8,
  localparam int CW = (N <= 2) ? 1 : $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_real,
  input  logic [W-1:0]  in_imag,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  a_real,
  output logic [W-1:0]  a_imag,
  output logic [W-1:0]  b_real,
  output logic [W-1:0]  b_imag,
  output logic          out_first,
  output logic          out_last,
  output logic [CW-1:0] out_row,
  output logic [CW-1:0] out_col,
  output logic          done
);

  localparam int AW = (N * N <= 2) ? 1 : $clog2(N * N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {LOAD_A, LOAD_B, ISSUE} state_t;

  state_t state, state_nxt;

  logic [CW-1:0] r, c;
  logic [CW-1:0] i, j, k;
  logic          in_fire, out_fire;
  logic          load_last, issue_last;

  logic [2*W-1:0] mem_a [N*N];
  logic [2*W-1:0] mem_b [N*N];
  logic [AW-1:0]  wr_addr, a_addr, b_addr;
  logic [2*W-1:0] a_word, b_word;

  assign in_ready   = !rst && (state != ISSUE);
  assign out_valid  = (state == ISSUE);
  assign in_fire    = in_valid && in_ready;
  assign out_fire   = out_valid && out_ready;
  assign load_last  = (r == LAST) && (c == LAST);
  assign issue_last = (i == LAST) && (j == LAST) && (k == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD_A;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD_A:  if (in_fire && load_last) state_nxt = LOAD_B;
      LOAD_B:  if (in_fire && load_last) state_nxt = ISSUE;
      ISSUE:   if (out_fire && issue_last) state_nxt = LOAD_A;
      default: state_nxt = LOAD_A;
    endcase
  end

  // Load and issue counters both wrap to zero, so each phase starts clean.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r    <= '0;
      c    <= '0;
      i    <= '0;
      j    <= '0;
      k    <= '0;
      done <= 1'b0;
    end else begin
      done <= out_fire && issue_last;
      if (in_fire) begin
        if (c == LAST) begin
          c <= '0;
          r <= (r == LAST) ? '0 : r + 1'b1;
        end else begin
          c <= c + 1'b1;
        end
      end
      if (out_fire) begin
        if (k == LAST) begin
          k <= '0;
          if (j == LAST) begin
            j <= '0;
            i <= (i == LAST) ? '0 : i + 1'b1;
          end else begin
            j <= j + 1'b1;
          end
        end else begin
          k <= k + 1'b1;
        end
      end
    end
  end

  assign wr_addr = AW'(int'(r) * N + int'(c));
  assign a_addr  = AW'(int'(i) * N + int'(k));
  assign b_addr  = AW'(int'(k) * N + int'(j));

  // Operand storage carries no reset; contents are don't-care until loaded.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      if (state == LOAD_A) begin
        mem_a[wr_addr] <= {in_real, in_imag};
      end else begin
        mem_b[wr_addr] <= {in_real, in_imag};
      end
    end
  end

  assign a_word    = mem_a[a_addr];
  assign b_word    = mem_b[b_addr];
  assign a_real    = a_word[2*W-1:W];
  assign a_imag    = a_word[W-1:0];
  assign b_real    = b_word[2*W-1:W];
  assign b_imag    = b_word[W-1:0];
  assign out_first = out_valid && (k == '0);
  assign out_last  = out_valid && (k == LAST);
  assign out_row   = i;
  assign out_col   = j;

endmodule

// File: tb/tb_cmat_operand_sequencer.sv
// tb/tb_cmat_operand_sequencer.sv - self-checking bench with a matrix-level reference model
module tb_cmat_operand_sequencer;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int CW = 2;
  localparam int N3 = N * N * N;

  typedef struct packed {
    logic [W-1:0]  ar;
    logic [W-1:0]  ai;
    logic [W-1:0]  br;
    logic [W-1:0]  bi;
    logic          first;
    logic          last;
    logic [CW-1:0] row;
    logic [CW-1:0] col;
  } pair_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_real;
  logic [W-1:0]  in_imag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  a_real, a_imag, b_real, b_imag;
  logic          out_first, out_last;
  logic [CW-1:0] out_row, out_col;
  logic          done;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] ma_re [N][N];
  logic [W-1:0] ma_im [N][N];
  logic [W-1:0] mb_re [N][N];
  logic [W-1:0] mb_im [N][N];

  cmat_operand_sequencer #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_real(in_real), .in_imag(in_imag),
    .out_valid(out_valid), .out_ready(out_ready),
    .a_real(a_real), .a_imag(a_imag), .b_real(b_real), .b_imag(b_imag),
    .out_first(out_first), .out_last(out_last), .out_row(out_row), .out_col(out_col),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fill_basic();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        ma_re[r][c] = W'(N * r + c);
        ma_im[r][c] = W'(N * r + c + 1);
        mb_re[r][c] = (r == c) ? 8'd1 : 8'd0;
        mb_im[r][c] = 8'd0;
      end
  endtask

  task automatic fill_random();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        ma_re[r][c] = W'($urandom);
        ma_im[r][c] = W'($urandom);
        mb_re[r][c] = W'($urandom);
        mb_im[r][c] = W'($urandom);
      end
  endtask

  task automatic fill_extremes();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        ma_re[r][c] = 8'h80;
        ma_im[r][c] = 8'h80;
        mb_re[r][c] = 8'h7f;
        mb_im[r][c] = 8'h7f;
      end
  endtask

  // mode 0: always valid, 1: 1,0,0,1 repeating, 2: random gaps
  task automatic load_job(input int mode, input int n_elems);
    int idx;
    int cyc;
    int e;
    bit v;
    idx = 0;
    cyc = 0;
    while (idx < n_elems && cyc < 2000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: v = 1'($urandom_range(0, 1));
      endcase
      in_valid = v;
      if (v) begin
        e = idx % (N * N);
        if (idx < N * N) begin
          in_real = ma_re[e / N][e % N];
          in_imag = ma_im[e / N][e % N];
        end else begin
          in_real = mb_re[e / N][e % N];
          in_imag = mb_im[e / N][e % N];
        end
      end else begin
        in_real = W'($urandom);
        in_imag = W'($urandom);
      end
      chk("load_in_ready", 64'(in_ready), 64'(1'b1));
      chk("load_out_valid", 64'(out_valid), 64'(1'b0));
      if (cyc > 0) chk("load_done", 64'(done), 64'(1'b0));
      @(posedge clk);
      if (v) idx++;
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    if (idx < n_elems) chk("load_timeout", 64'(idx), 64'(n_elems));
  endtask

  // mode 0: out_ready high, 1: 3-cycle stall at transfer 5, 2: random backpressure
  task automatic run_issue(input int mode, input int abort_at);
    pair_t q[$];
    pair_t p;
    pair_t obs;
    int t;
    int cyc;
    int stalls;
    int vcycles;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        for (int k = 0; k < N; k++) begin
          p.ar    = ma_re[i][k];
          p.ai    = ma_im[i][k];
          p.br    = mb_re[k][j];
          p.bi    = mb_im[k][j];
          p.first = (k == 0);
          p.last  = (k == N - 1);
          p.row   = CW'(i);
          p.col   = CW'(j);
          q.push_back(p);
        end
    t = 0;
    cyc = 0;
    stalls = 0;
    vcycles = 0;
    while (t < N3 && cyc < 1000) begin
      if (t == abort_at) begin
        rst = 1'b1;
        #1;
        chk("abort_out_valid", 64'(out_valid), 64'(1'b0));
        chk("abort_in_ready", 64'(in_ready), 64'(1'b0));
        chk("abort_done", 64'(done), 64'(1'b0));
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_release_in_ready", 64'(in_ready), 64'(1'b1));
        chk("abort_release_done", 64'(done), 64'(1'b0));
        return;
      end
      case (mode)
        0: out_ready = 1'b1;
        1: if (t == 5 && stalls < 3) begin
             out_ready = 1'b0;
             stalls++;
           end else begin
             out_ready = 1'b1;
           end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      in_valid = 1'b1;
      in_real  = W'($urandom);
      in_imag  = W'($urandom);
      chk("issue_out_valid", 64'(out_valid), 64'(1'b1));
      chk("issue_in_ready", 64'(in_ready), 64'(1'b0));
      chk("issue_done", 64'(done), 64'(1'b0));
      obs = {a_real, a_imag, b_real, b_imag, out_first, out_last, out_row, out_col};
      chk($sformatf("pair%0d", t), 64'(obs), 64'(q[t]));
      vcycles++;
      @(posedge clk);
      if (out_ready) t++;
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    if (t < N3) chk("issue_timeout", 64'(t), 64'(N3));
    if (mode == 0) chk("issue_cycles", 64'(vcycles), 64'(N3));
    if (mode == 1) chk("issue_cycles_bp", 64'(vcycles), 64'(N3 + 3));
    chk("end_out_valid", 64'(out_valid), 64'(1'b0));
    chk("end_done", 64'(done), 64'(1'b1));
    chk("end_in_ready", 64'(in_ready), 64'(1'b1));
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
    chk("idle_done", 64'(done), 64'(1'b0));
    chk("idle_out_valid", 64'(out_valid), 64'(1'b0));
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_real = '0;
    in_imag = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'(1'b0));
    chk("rst_out_valid", 64'(out_valid), 64'(1'b0));
    chk("rst_done", 64'(done), 64'(1'b0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'(1'b1));

    // basic job, identity B
    fill_basic();
    load_job(0, 2 * N * N);
    run_issue(0, -1);

    // back-to-back job with output backpressure
    fill_random();
    load_job(0, 2 * N * N);
    run_issue(1, -1);
    idle_cycle();

    // input stalls, elements presented during ISSUE ignored
    fill_basic();
    load_job(1, 2 * N * N);
    run_issue(0, -1);
    idle_cycle();

    // signed extremes with random gaps and backpressure
    fill_extremes();
    load_job(2, 2 * N * N);
    run_issue(2, -1);
    idle_cycle();

    // reset mid-load discards partial data
    fill_random();
    load_job(0, 10);
    rst = 1'b1;
    #1;
    chk("midload_rst_in_ready", 64'(in_ready), 64'(1'b0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    fill_random();
    load_job(2, 2 * N * N);
    run_issue(0, -1);
    idle_cycle();

    // reset mid-issue at transfer 20, then a fresh job
    fill_random();
    load_job(0, 2 * N * N);
    run_issue(0, 20);
    idle_cycle();
    fill_random();
    load_job(2, 2 * N * N);
    run_issue(2, -1);
    idle_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
